// File: rtl/flex_countdown_timer.sv
// flex_countdown_timer: loadable down-counter that pulses expire_flag when the
// count reaches zero, optionally reloading the last loaded value for periodic use.
module flex_countdown_timer #(
    parameter int NUM_CNT_BITS = 4,
    parameter bit AUTO_RELOAD  = 1'b0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        EXPIRE = 2'b10
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    state_t                  state, next_state;
    logic [NUM_CNT_BITS-1:0] reload_reg, next_reload;
    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    next_expire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, so it sits inside the edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            count_out   <= '0;
            reload_reg  <= '0;
            expire_flag <= 1'b0;
        end else begin
            state       <= next_state;
            count_out   <= next_count;
            reload_reg  <= next_reload;
            expire_flag <= next_expire;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state  = state;
        next_count  = count_out;
        next_reload = reload_reg;
        next_expire = 1'b0;
        if (clear) begin
            next_state = IDLE;
            next_count = '0;
        end else if (load) begin
            // A zero load expires immediately rather than idling in RUN at 0.
            next_reload = load_val;
            next_count  = load_val;
            if (load_val != '0) begin
                next_state = RUN;
            end else begin
                next_state  = EXPIRE;
                next_expire = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (count_enable) begin
                        if (count_out > ONE) begin
                            next_count = count_out - ONE;
                        end else begin
                            next_count  = '0;
                            next_expire = 1'b1;
                            next_state  = EXPIRE;
                        end
                    end
                end
                EXPIRE: begin
                    if (AUTO_RELOAD && (reload_reg != '0)) begin
                        next_count = reload_reg;
                        next_state = RUN;
                    end else begin
                        next_count = '0;
                        next_state = IDLE;
                    end
                end
                IDLE:    next_state = IDLE;
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule
